// File: rtl/alu_serial_sequencer.sv
// Bit-serial WIDTH-bit ALU sequencer: drives one external 1-bit ALU slice LSB first,
// chains carry through a flop and hands back result plus flags over valid/ready.
module alu_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_ctl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_ainvert,
  output logic             slice_bnegate,
  output logic [2:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
  logic [2:0]       op_q, op_d;
  logic ainv_q, ainv_d, bneg_q, bneg_d, arith_q, arith_d, slt_q, slt_d, ill_q, ill_d;
  logic carry_q, carry_d, zero_q, zero_d, cflag_q, cflag_d, ovf_q, ovf_d;

  logic             dec_ainv, dec_bneg, dec_arith, dec_slt, dec_ill;
  logic [2:0]       dec_op;
  logic             last_bit;
  logic [WIDTH-1:0] res_bits, fin_result;
  logic             fin_ovf;

  assign last_bit = (bit_idx_q == LastIdx);

  // Illegal codes decode as a plain AND so the slice still sees a defined op.
  always_comb begin
    dec_ainv  = 1'b0;
    dec_bneg  = 1'b0;
    dec_op    = 3'b000;
    dec_arith = 1'b0;
    dec_slt   = 1'b0;
    dec_ill   = 1'b0;
    unique case (in_ctl)
      4'b0000: begin end
      4'b0001: dec_op = 3'b001;
      4'b0010: begin dec_op = 3'b010; dec_arith = 1'b1; end
      4'b0110: begin dec_op = 3'b010; dec_arith = 1'b1; dec_bneg = 1'b1; end
      4'b0111: begin dec_op = 3'b010; dec_arith = 1'b1; dec_bneg = 1'b1; dec_slt = 1'b1; end
      4'b1100: begin dec_ainv = 1'b1; dec_bneg = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (last_bit)  state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_cin     = 1'b0;
    slice_ainvert = 1'b0;
    slice_bnegate = 1'b0;
    slice_op      = 3'b000;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        slice_a       = a_q[bit_idx_q];
        slice_b       = b_q[bit_idx_q];
        slice_cin     = carry_q;
        slice_ainvert = ainv_q;
        slice_bnegate = bneg_q;
        slice_op      = op_q;
      end
      StDone: out_valid = 1'b1;
      default: begin end
    endcase
  end

  // On the MSB edge carry_q is still the MSB carry-in, so overflow is cin ^ cout there.
  always_comb begin
    res_bits            = res_q;
    res_bits[bit_idx_q] = slice_result;
    fin_ovf             = arith_q & (carry_q ^ slice_cout);
    fin_result          = res_bits;
    if (ill_q) begin
      fin_result = '0;
    end else if (slt_q) begin
      fin_result    = '0;
      fin_result[0] = res_bits[WIDTH-1] ^ fin_ovf;
    end
  end

  always_comb begin
    a_d = a_q;  b_d = b_q;  op_d = op_q;
    ainv_d = ainv_q;  bneg_d = bneg_q;  arith_d = arith_q;  slt_d = slt_q;  ill_d = ill_q;
    bit_idx_d = bit_idx_q;  carry_d = carry_q;  res_d = res_q;
    result_d = result_q;  zero_d = zero_q;  cflag_d = cflag_q;  ovf_d = ovf_q;
    if (state_q == StIdle && in_valid) begin
      a_d = in_a;  b_d = in_b;  op_d = dec_op;
      ainv_d = dec_ainv;  bneg_d = dec_bneg;  arith_d = dec_arith;
      slt_d = dec_slt;  ill_d = dec_ill;
      bit_idx_d = '0;  carry_d = dec_bneg;  res_d = '0;
    end else if (state_q == StRun) begin
      res_d   = res_bits;
      carry_d = slice_cout;
      if (!last_bit) begin
        bit_idx_d = bit_idx_q + 1'b1;
      end else begin
        result_d = fin_result;
        zero_d   = (fin_result == '0);
        cflag_d  = arith_q & slice_cout;
        ovf_d    = fin_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;  b_q <= '0;  op_q <= '0;
      ainv_q <= 1'b0;  bneg_q <= 1'b0;  arith_q <= 1'b0;  slt_q <= 1'b0;  ill_q <= 1'b0;
      bit_idx_q <= '0;  carry_q <= 1'b0;  res_q <= '0;
      result_q <= '0;  zero_q <= 1'b0;  cflag_q <= 1'b0;  ovf_q <= 1'b0;
    end else begin
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;
      ainv_q <= ainv_d;  bneg_q <= bneg_d;  arith_q <= arith_d;  slt_q <= slt_d;  ill_q <= ill_d;
      bit_idx_q <= bit_idx_d;  carry_q <= carry_d;  res_q <= res_d;
      result_q <= result_d;  zero_q <= zero_d;  cflag_q <= cflag_d;  ovf_q <= ovf_d;
    end
  end

  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_carry    = cflag_q;
  assign out_overflow = ovf_q;
  assign out_illegal  = ill_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Bench for alu_serial_sequencer at WIDTH=8 with a behavioural 1-bit slice and an
// arithmetic reference model for randomized operations.
module tb_alu_serial_sequencer;

  localparam int W = 8;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_result;
  logic [3:0]   in_ctl;
  logic         out_zero, out_carry, out_overflow, out_illegal;
  logic         slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate;
  logic [2:0]   slice_op;
  logic         slice_result, slice_cout;

  int n_tests = 0;
  int n_fail  = 0;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctl(in_ctl),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_illegal(out_illegal),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_ainvert(slice_ainvert), .slice_bnegate(slice_bnegate), .slice_op(slice_op),
    .slice_result(slice_result), .slice_cout(slice_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit ALU slice
  logic sa, sb;
  always_comb begin
    sa         = slice_a ^ slice_ainvert;
    sb         = slice_b ^ slice_bnegate;
    slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
    case (slice_op)
      3'b000:  slice_result = sa & sb;
      3'b001:  slice_result = sa | sb;
      3'b010:  slice_result = sa ^ sb ^ slice_cin;
      default: slice_result = 1'b0;
    endcase
  end

  function automatic void ref_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic z, output logic c,
                                 output logic v, output logic il);
    logic [W:0] s;
    s = '0; r = '0; c = 1'b0; v = 1'b0; il = 1'b0;
    case (ctl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      4'b0110, 4'b0111: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        c = s[W];
        v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        if (ctl == 4'b0110) r = s[W-1:0];
        else r = ($signed(a) < $signed(b)) ? 1 : 0;
      end
      default: il = 1'b1;
    endcase
    z = (r == 0);
  endfunction

  // lat counts clock edges with the acceptance edge as edge 1.
  task automatic run_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic z, output logic c,
                        output logic v, output logic il, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_ctl = ctl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_ctl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    r = out_result; z = out_zero; c = out_carry; v = out_overflow; il = out_illegal;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++;
    if ({out_result, out_zero, out_carry, out_overflow, out_illegal} !== 12'h0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 000",
                         {out_result, out_zero, out_carry, out_overflow, out_illegal});
    end
    n_tests++;
    if ({slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate, slice_op} !== 8'h0) begin
      n_fail++; $display("FAIL reset_slice got %h want 00",
                         {slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate, slice_op});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_add;
    logic [W-1:0] r; logic z, c, v, il; int lat;
    run_op(4'b0010, 8'h7F, 8'h01, r, z, c, v, il, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL add_latency got %0d want 9", lat); end
    n_tests++; if (r !== 8'h80) begin n_fail++; $display("FAIL add_result got %h want 80", r); end
    n_tests++; if ({z, c, v, il} !== 4'b0010) begin
      n_fail++; $display("FAIL add_flags zcvi got %b want 0010", {z, c, v, il}); end
  endtask

  task automatic test_sub;
    logic [W-1:0] r; logic z, c, v, il; int lat;
    run_op(4'b0110, 8'h05, 8'h05, r, z, c, v, il, lat);
    n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL sub_eq_result got %h want 00", r); end
    n_tests++; if ({z, c, v, il} !== 4'b1100) begin
      n_fail++; $display("FAIL sub_eq_flags zcvi got %b want 1100", {z, c, v, il}); end
    run_op(4'b0110, 8'h00, 8'h01, r, z, c, v, il, lat);
    n_tests++; if (r !== 8'hFF) begin n_fail++; $display("FAIL sub_borrow_result got %h want ff", r); end
    n_tests++; if (c !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_carry got %b want 0", c); end
  endtask

  task automatic test_slt;
    logic [W-1:0] r; logic z, c, v, il; int lat;
    run_op(4'b0111, 8'h80, 8'h01, r, z, c, v, il, lat);
    n_tests++; if (r !== 8'h01) begin n_fail++; $display("FAIL slt_neg_result got %h want 01", r); end
    run_op(4'b0111, 8'h7F, 8'h80, r, z, c, v, il, lat);
    n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL slt_ovf_result got %h want 00", r); end
    n_tests++; if ({z, v} !== 2'b11) begin
      n_fail++; $display("FAIL slt_ovf_flags zv got %b want 11", {z, v}); end
  endtask

  task automatic test_logic;
    logic [W-1:0] r; logic z, c, v, il; int lat;
    run_op(4'b0000, 8'hF0, 8'h3C, r, z, c, v, il, lat);
    n_tests++; if ({r, z, c, v, il} !== {8'h30, 4'b0000}) begin
      n_fail++; $display("FAIL and got %h/%b want 30/0000", r, {z, c, v, il}); end
    run_op(4'b0001, 8'hF0, 8'h3C, r, z, c, v, il, lat);
    n_tests++; if ({r, z, c, v, il} !== {8'hFC, 4'b0000}) begin
      n_fail++; $display("FAIL or got %h/%b want fc/0000", r, {z, c, v, il}); end
    run_op(4'b1100, 8'hF0, 8'h0F, r, z, c, v, il, lat);
    n_tests++; if ({r, z, c, v, il} !== {8'h00, 4'b1000}) begin
      n_fail++; $display("FAIL nor got %h/%b want 00/1000", r, {z, c, v, il}); end
    run_op(4'b0101, 8'hFF, 8'hFF, r, z, c, v, il, lat);
    n_tests++; if ({r, c, v, il} !== {8'h00, 3'b001}) begin
      n_fail++; $display("FAIL illegal got %h/%b want 00/001", r, {c, v, il}); end
  endtask

  task automatic test_backpressure;
    logic [W+3:0] held; int k;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_ctl = 4'b0010;
    @(posedge clk); #1; in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    held = {out_result, out_zero, out_carry, out_overflow, out_illegal};
    n_tests++; if (held !== {8'h46, 4'b0000}) begin
      n_fail++; $display("FAIL bp_first_result got %h want 460", held); end
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h03; in_b = 8'h04; in_ctl = 4'b0010;
    repeat (5) begin
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
      n_tests++; if ({out_result, out_zero, out_carry, out_overflow, out_illegal} !== held) begin
        n_fail++; $display("FAIL bp_hold got %h want %h",
                           {out_result, out_zero, out_carry, out_overflow, out_illegal}, held); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_tests++; if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_handoff valid/ready got %b want 01", {out_valid, in_ready}); end
    @(posedge clk); #1; in_valid = 1'b0;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_queued_accept got %b want 0", in_ready); end
    k = 1;
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    n_tests++; if (k !== 9) begin n_fail++; $display("FAIL bp_queued_latency got %0d want 9", k); end
    n_tests++; if (out_result !== 8'h07) begin n_fail++; $display("FAIL bp_queued_result got %h want 07", out_result); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] r; logic z, c, v, il; int lat;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h0F; in_ctl = 4'b0010;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    n_tests++; if (slice_cin !== 1'b1) begin n_fail++; $display("FAIL midrun_cin got %b want 1", slice_cin); end
    reset = 1'b1;
    #1;
    n_tests++; if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL midrun_reset ready/valid got %b want 10", {in_ready, out_valid}); end
    n_tests++; if ({out_result, out_zero, out_carry, out_overflow, out_illegal,
                    slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate, slice_op} !== 20'h0) begin
      n_fail++; $display("FAIL midrun_reset_outputs got %h want 00000",
                         {out_result, out_zero, out_carry, out_overflow, out_illegal,
                          slice_a, slice_b, slice_cin, slice_ainvert, slice_bnegate, slice_op}); end
    @(negedge clk); reset = 1'b0;
    run_op(4'b0010, 8'h01, 8'h01, r, z, c, v, il, lat);
    n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL post_reset_latency got %0d want 9", lat); end
    n_tests++; if (r !== 8'h02) begin n_fail++; $display("FAIL post_reset_result got %h want 02", r); end
  endtask

  task automatic test_random;
    logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [W-1:0] a, b, r, er; logic z, c, v, il, ez, ec, ev, eil; logic [3:0] ctl; int lat;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom);
      ctl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 5)];
      ref_op(ctl, a, b, er, ez, ec, ev, eil);
      run_op(ctl, a, b, r, z, c, v, il, lat);
      n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL rand_latency ctl=%b got %0d want 9", ctl, lat); end
      n_tests++; if (r !== er) begin
        n_fail++; $display("FAIL rand_result ctl=%b a=%h b=%h got %h want %h", ctl, a, b, r, er); end
      n_tests++; if ({z, c, v, il} !== {ez, ec, ev, eil}) begin
        n_fail++; $display("FAIL rand_flags ctl=%b a=%h b=%h zcvi got %b want %b",
                           ctl, a, b, {z, c, v, il}, {ez, ec, ev, eil}); end
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_ctl = '0; reset = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Bit-serial sequencer that sits directly around the 1-bit ALU slice. It accepts a full-width operand pair plus a 4-bit ALU control code and drives one slice bit per cycle, LSB first, carrying cout back into cin through a flop. It collects result bits into a word and reports zero/carry/overflow and SLT over a valid/ready handshake. This gives the datapath a WIDTH-bit ALU using a single slice instance, which is external to this block.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand/control request valid
in_ready  output  1  sequencer can accept request
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_ctl  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result word
out_zero  output  1  out_result == 0
out_carry  output  1  final carry (ADD/SUB/SLT only, else 0)
out_overflow  output  1  signed overflow (ADD/SUB/SLT only, else 0)
out_illegal  output  1  in_ctl was not one of the six codes
slice_a, slice_b, slice_cin  output  1 each  bit drive to slice
slice_ainvert, slice_bnegate  output  1 each  slice invert controls
slice_op  output  3  slice op: 000 AND, 001 OR, 010 ADD
slice_result, slice_cout  input  1 each  slice outputs (combinational from slice drives)

Behaviour:
- Reset (async, any state, including mid-RUN): state IDLE; in_ready=1; out_valid=0; out_result=0; all flags 0; all slice_* outputs 0; the in-progress op is discarded.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_a, in_b and in_ctl; set bit_idx=0 and carry_reg=in_ctl[2]; go to RUN.
- Control decode: ainvert=ctl[3]; bnegate=ctl[2]; slice_op = 000 for AND/NOR, 001 for OR, 010 for ADD/SUB/SLT. Illegal code: decode as AND, out_result forced to 0, out_illegal=1.
- RUN: in_ready=0. slice_a=a_reg[bit_idx], slice_b=b_reg[bit_idx], slice_cin=carry_reg; slice_ainvert, slice_bnegate and slice_op come from the latched control.
- Each RUN edge: res_reg[bit_idx]<=slice_result; carry_reg<=slice_cout; bit_idx++.
- On the edge where bit_idx==WIDTH-1, also capture msb_cin=carry_reg; then go to DONE.
- RUN lasts exactly WIDTH cycles.
- Entering DONE:
  - out_overflow = msb_cin ^ final carry (arith only).
  - SLT: out_result = {0…0, res_reg[WIDTH-1]^overflow}; carry and overflow still reported.
  - out_zero is computed on the final out_result.
- DONE: out_valid=1; all outputs held stable until out_valid&out_ready, then go to IDLE with out_valid=0. Slice drives are 0 outside RUN.
- Throughput: one op per WIDTH+2 cycles minimum (accept edge, WIDTH RUN edges, handoff edge). No overlap: in_ready=0 in RUN and DONE.
- in_* ignored outside IDLE; changes to in_* during RUN do not affect the op.
- bit_idx width clog2(WIDTH); no wrap past WIDTH-1.

Test Plan:
Bench uses WIDTH=8 and a behavioural 1-bit slice model wired to the slice_* ports.
1. ADD 0x7F+0x01 -> out_valid asserted exactly 9 edges after acceptance; result 0x80, overflow=1, carry=0, zero=0.
2. SUB 0x05-0x05 -> result 0x00, zero=1, carry=1, overflow=0. SUB 0x00-0x01 -> 0xFF, carry=0.
3. SLT 0x80 vs 0x01 -> result 0x01. SLT 0x7F vs 0x80 -> result 0x00, overflow=1.
4. AND 0xF0,0x3C -> 0x30; OR -> 0xFC; NOR 0xF0,0x0F -> 0x00, zero=1; all with carry=0, overflow=0. Code 0101 -> result 0x00, illegal=1.
5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is not accepted. Then out_ready=1 -> IDLE next edge and the queued request is accepted.
6. Assert reset at RUN bit 4 -> all outputs 0 immediately (asynchronous). Next op ADD 0x01+0x01 -> 0x02 with correct 9-edge latency.
